pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//   Consumer side of the hazard-stall interface. Takes stall requests (load-use from the ID hazard
//   check, data-memory wait, taken-branch redirect) and drives the stage enables: PC write, IF/ID
//   write/flush, ID/EX bubble, EX/MEM hold. Sequences multi-cycle stalls and flushes with an FSM.
//   Sits beside the pipeline registers in the top-level datapath.
// PARAMETERS
//   PC_W          32  PC / branch target width
//   LU_CYCLES      1  load-use stall length in cycles (>=1)
//   FLUSH_CYCLES   2  bubble cycles after a taken branch (>=1)
//   CNT_W         16  width of stall/flush counters (only with STALL_PERF_CNT_EN)
// PORTS
//   clk              in   1      rising-edge clock
//   rst_n            in   1      asynchronous active-low reset
//   stall_req_i      in   1      load-use hazard detected in ID (combinational, same cycle)
//   mem_busy_i       in   1      data memory not ready; freeze whole pipe
//   branch_taken_i   in   1      taken branch resolved in MEM
//   branch_target_i  in   PC_W   redirect address, valid with branch_taken_i
//   pc_en_o          out  1      PC register write enable
//   pc_load_o        out  1      load PC from pc_load_val_o (overrides increment)
//   pc_load_val_o    out  PC_W   redirect value (= branch_target_i when pc_load_o)
//   ifid_en_o        out  1      IF/ID register write enable
//   ifid_flush_o     out  1      IF/ID clears to NOP
//   idex_bubble_o    out  1      zero control lines into ID/EX
//   exmem_en_o       out  1      EX/MEM and MEM/WB write enable
//   state_o          out  2      current FSM state (debug)
//   stall_cnt_o      out  CNT_W  load-use + mem-wait stall cycles (feature only)
//   flush_cnt_o      out  CNT_W  flush cycles (feature only)
// BEHAVIOUR
//   - Outputs are Mealy: decoded from registered state + current inputs, so a request takes
//     effect in the cycle it is raised. State/counter registers update on posedge clk.
//   - States: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3. Down-counter cnt (8b), ret_state (2b).
//   - Priority every cycle: mem_busy_i > branch_taken_i > stall_req_i > normal.
//   - RUN, no request: pc_en=ifid_en=exmem_en=1, others 0.
//   - mem_busy_i (any state): all enables 0, no flush, no bubble; ret_state<=state unless state is
//     MEM_WAIT; cnt frozen; next MEM_WAIT. MEM_WAIT with mem_busy_i=0 decodes as ret_state this cycle.
//   - branch_taken_i (RUN/LU_STALL/FLUSH): pc_en=1, pc_load=1, pc_load_val=branch_target_i,
//     ifid_flush=1, idex_bubble=1, exmem_en=1; cnt<=FLUSH_CYCLES-1; next FLUSH, or RUN if
//     FLUSH_CYCLES==1. Branch aborts a pending load-use stall.
//   - stall_req_i in RUN: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; cnt<=LU_CYCLES-1;
//     next LU_STALL, or RUN if LU_CYCLES==1. stall_req_i ignored in LU_STALL/FLUSH.
//   - LU_STALL: same outputs as stall; cnt decrements; cnt==1 -> RUN.
//   - FLUSH: pc_en=1, ifid_flush=1, idex_bubble=1, exmem_en=1; cnt decrements; cnt==1 -> RUN.
//   - pc_load_val_o = 0 whenever pc_load_o=0.
//   - Reset (rst_n=0, async): state=RUN, cnt=0, ret_state=RUN, counters=0; while rst_n=0 outputs
//     forced pc_en=ifid_en=exmem_en=pc_load=0, ifid_flush=idex_bubble=1, pc_load_val=0, state_o=0.
//     Reset mid-stall abandons it; first cycle after release is RUN.
// CONFIGURATION
//   `STALL_PERF_CNT_EN defined: stall_cnt_o +1 per cycle with pc_en_o=0 (excl. reset), flush_cnt_o
//   +1 per cycle with ifid_flush_o=1 (excl. reset); both saturate at all-ones, never wrap.
//   Undefined: ports remain, tied to 0; no counter flops synthesised.
// STRUCTURE
//   pipe_ctrl_defs.vh: state encodings (ST_RUN..ST_FLUSH), cnt width, default cycle constants;
//   shared with stall_unit bench and top-level for state_o decode.
//   One sub-module: sat_counter #(W) (clk, rst_n, inc, q) used twice under the macro.
// TESTING
//   1 stall_req_i=1 one cycle, LU_CYCLES=1 -> that cycle pc_en=0, ifid_en=0, bubble=1; next RUN.
//   2 LU_CYCLES=3, stall_req_i pulse -> 3 consecutive stall cycles, state_o 1,1 then 0 on cycle 4.
//   3 branch_taken_i, target=32'h0000_0040 -> pc_load=1, val=0x40, flush+bubble 2 cycles, then RUN.
//   4 mem_busy_i high 4 cycles during FLUSH cnt=1 -> all enables 0 for 4 cycles, then 1 FLUSH cycle.
//   5 branch_taken_i and stall_req_i same cycle -> branch wins: pc_load=1, state FLUSH, no LU_STALL.
//   6 rst_n low mid-LU_STALL -> outputs forced reset values at once; after release RUN, counters 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared state encodings, stall counter width and default cycle lengths.
package pipeline_stall_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;
    localparam int CNT_BITS         = 8;
    localparam int DEF_LU_CYCLES    = 1;
    localparam int DEF_FLUSH_CYCLES = 2;
    typedef logic [CNT_BITS-1:0] cnt_t;
    function automatic cnt_t init_cnt(input int cycles);
        return cnt_t'(cycles - 1);
    endfunction
endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (inc && r_q != '1)
            r_q <= r_q + W'(1);
    end
    assign q = r_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: turns load-use, memory-wait and branch requests into pipeline stage enables.
// Define STALL_PERF_CNT_EN to add saturating stall/flush cycle counters (tied to 0 otherwise).
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int LU_CYCLES    = DEF_LU_CYCLES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req_i,
    input  logic             mem_busy_i,
    input  logic             branch_taken_i,
    input  logic [PC_W-1:0]  branch_target_i,
    output logic             pc_en_o,
    output logic             pc_load_o,
    output logic [PC_W-1:0]  pc_load_val_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_en_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    state_t r_state, r_ret, w_eff, w_state_nx, w_ret_nx;
    cnt_t   r_cnt, w_cnt_nx;

    // MEM_WAIT is transparent once memory is ready: behave as the state it interrupted.
    assign w_eff = (r_state == ST_MEM_WAIT) ? r_ret : r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_ret   <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ret   <= w_ret_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = w_eff;
        w_ret_nx   = r_ret;
        w_cnt_nx   = r_cnt;
        if (mem_busy_i) begin
            w_state_nx = ST_MEM_WAIT;
            w_ret_nx   = (r_state == ST_MEM_WAIT) ? r_ret : r_state;
        end else if (branch_taken_i) begin
            w_cnt_nx   = init_cnt(FLUSH_CYCLES);
            w_state_nx = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end else if (w_eff == ST_RUN) begin
            if (stall_req_i) begin
                w_cnt_nx   = init_cnt(LU_CYCLES);
                w_state_nx = (LU_CYCLES == 1) ? ST_RUN : ST_LU_STALL;
            end
        end else begin
            w_cnt_nx   = r_cnt - cnt_t'(1);
            w_state_nx = (r_cnt == cnt_t'(1)) ? ST_RUN : w_eff;
        end
    end

    always_comb begin
        pc_en_o       = 1'b0;
        pc_load_o     = 1'b0;
        ifid_en_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_en_o    = 1'b0;
        if (!rst_n) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (mem_busy_i) begin
        end else if (branch_taken_i) begin
            pc_en_o       = 1'b1;
            pc_load_o     = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            exmem_en_o    = 1'b1;
        end else if (w_eff == ST_FLUSH) begin
            pc_en_o       = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            exmem_en_o    = 1'b1;
        end else if (w_eff == ST_LU_STALL || stall_req_i) begin
            idex_bubble_o = 1'b1;
            exmem_en_o    = 1'b1;
        end else begin
            pc_en_o       = 1'b1;
            ifid_en_o     = 1'b1;
            exmem_en_o    = 1'b1;
        end
    end

    assign pc_load_val_o = pc_load_o ? branch_target_i : '0;
    assign state_o       = rst_n ? r_state : ST_RUN;

`ifdef STALL_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_en_o),
        .q     (stall_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush_o),
        .q     (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed scenarios then random traffic against a remaining-cycles model.
module tb_pipeline_stall_ctrl;
    localparam int PC_W = 32;
    localparam int LU   = 3;
    localparam int FL   = 2;
    localparam int CW   = 16;
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall_req_i = 1'b0;
    logic            mem_busy_i = 1'b0;
    logic            branch_taken_i = 1'b0;
    logic [PC_W-1:0] branch_target_i = '0;
    logic            pc_en_o, pc_load_o, ifid_en_o, ifid_flush_o, idex_bubble_o, exmem_en_o;
    logic [PC_W-1:0] pc_load_val_o;
    logic [1:0]      state_o;
    logic [CW-1:0]   stall_cnt_o, flush_cnt_o;

    int     n_chk = 0;
    int     n_err = 0;
    int     m_lu = 0;
    int     m_fl = 0;
    int     m_st = 0;
    longint m_sc = 0;
    longint m_fc = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.PC_W(PC_W), .LU_CYCLES(LU), .FLUSH_CYCLES(FL), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_req_i     (stall_req_i),
        .mem_busy_i      (mem_busy_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .pc_en_o         (pc_en_o),
        .pc_load_o       (pc_load_o),
        .pc_load_val_o   (pc_load_val_o),
        .ifid_en_o       (ifid_en_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_bubble_o   (idex_bubble_o),
        .exmem_en_o      (exmem_en_o),
        .state_o         (state_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model keeps only "flush cycles left" and "stall cycles left"; a memory wait freezes both.
    task automatic step(input bit rn, input bit mb, input bit bt, input bit sr, input logic [31:0] tgt);
        bit e_pe, e_pl, e_ie, e_if, e_bb, e_ee;
        rst_n = rn; mem_busy_i = mb; branch_taken_i = bt; stall_req_i = sr; branch_target_i = tgt;
        #4;
        {e_pe, e_pl, e_ie, e_if, e_bb, e_ee} = 6'b0;
        if (!rn) begin
            e_if = 1; e_bb = 1;
        end else if (mb) begin
        end else if (bt) begin
            e_pe = 1; e_pl = 1; e_if = 1; e_bb = 1; e_ee = 1;
        end else if (m_fl > 0) begin
            e_pe = 1; e_if = 1; e_bb = 1; e_ee = 1;
        end else if (m_lu > 0 || sr) begin
            e_bb = 1; e_ee = 1;
        end else begin
            e_pe = 1; e_ie = 1; e_ee = 1;
        end
        check("pc_en", 64'(pc_en_o), 64'(e_pe));
        check("pc_load", 64'(pc_load_o), 64'(e_pl));
        check("pc_load_val", 64'(pc_load_val_o), e_pl ? 64'(tgt) : 64'd0);
        check("ifid_en", 64'(ifid_en_o), 64'(e_ie));
        check("ifid_flush", 64'(ifid_flush_o), 64'(e_if));
        check("idex_bubble", 64'(idex_bubble_o), 64'(e_bb));
        check("exmem_en", 64'(exmem_en_o), 64'(e_ee));
        check("state", 64'(state_o), rn ? 64'(m_st) : 64'd0);
`ifdef STALL_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt_o), 64'(m_sc));
        check("flush_cnt", 64'(flush_cnt_o), 64'(m_fc));
`else
        check("stall_cnt", 64'(stall_cnt_o), 64'd0);
        check("flush_cnt", 64'(flush_cnt_o), 64'd0);
`endif
        if (!rn) begin
            m_lu = 0; m_fl = 0; m_st = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (!e_pe && m_sc < CMAX) m_sc++;
            if (e_if && m_fc < CMAX) m_fc++;
            if (mb) m_st = 2;
            else begin
                if (bt) begin
                    m_fl = FL - 1; m_lu = 0;
                end else if (m_fl > 0) m_fl--;
                else if (m_lu > 0) m_lu--;
                else if (sr) m_lu = LU - 1;
                m_st = (m_fl > 0) ? 3 : (m_lu > 0) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released between clock edges, so only an asynchronous reset clears state.
    task automatic rst_pulse();
        rst_n = 0; stall_req_i = 0; mem_busy_i = 0; branch_taken_i = 0;
        #1;
        check("rst_pc_en", 64'(pc_en_o), 64'd0);
        check("rst_ifid_en", 64'(ifid_en_o), 64'd0);
        check("rst_exmem_en", 64'(exmem_en_o), 64'd0);
        check("rst_pc_load", 64'(pc_load_o), 64'd0);
        check("rst_flush", 64'(ifid_flush_o), 64'd1);
        check("rst_bubble", 64'(idex_bubble_o), 64'd1);
        check("rst_state", 64'(state_o), 64'd0);
        #1;
        rst_n = 1;
        m_lu = 0; m_fl = 0; m_st = 0; m_sc = 0; m_fc = 0;
    endtask

    initial begin
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        repeat (4) step(1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0000_0040);
        repeat (3) step(1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0000_1234);
        repeat (4) step(1, 1, 0, 0, 32'h0);
        repeat (2) step(1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 1, 32'h0000_0080);
        repeat (3) step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        rst_pulse();
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) != 0, $urandom_range(99) < 15, $urandom_range(99) < 10,
                 $urandom_range(99) < 30, $urandom);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
